// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and the strobe bundle shared by the sequencer, decoder and ALU
// Contents: OP_* opcode constants, state_t (IRQ state only with CPU_IRQ_EN), strobe_t bundle
package cpu_pkg;
   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;
   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_INC   = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3
`ifdef CPU_IRQ_EN
      , ST_IRQ = 3'd4
`endif
   } state_t;
   typedef struct packed {
      logic pc_en, pc_in, pc_vec, addr_sel, mem_rd, mem_wr, ir_load, acc_load, halted, irq_ack;
      logic [2:0] alu_op;
   } strobe_t;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational map from (state, opcode, zero) to the datapath strobe bundle
// Ports: state_i current FSM state, opcode_i IR[7:5], zero_i accumulator-zero, strb_o strobes
// Config: CPU_IRQ_EN adds the IRQ-state vector load and acknowledge
module seq_decode
   import cpu_pkg::*;
(
   input  state_t     state_i,
   input  logic [2:0] opcode_i,
   input  logic       zero_i,
   output strobe_t    strb_o
);
   logic ex, alu;
   always_comb begin
      ex              = state_i == ST_EXEC;
      alu             = ex && (opcode_i inside {OP_ADD, OP_AND, OP_XOR, OP_LDA});
      strb_o          = '0;
      strb_o.pc_en    = (state_i == ST_INC) || (ex && ((opcode_i == OP_JMP) || ((opcode_i == OP_SKZ) && zero_i)));
      strb_o.pc_in    = ex && (opcode_i == OP_JMP);
      strb_o.addr_sel = alu || (ex && (opcode_i == OP_STO));
      strb_o.mem_rd   = (state_i == ST_FETCH) || alu;
      strb_o.mem_wr   = ex && (opcode_i == OP_STO);
      strb_o.ir_load  = state_i == ST_FETCH;
      strb_o.acc_load = alu;
      strb_o.halted   = state_i == ST_HALT;
      strb_o.alu_op   = ex ? opcode_i : OP_HLT;
`ifdef CPU_IRQ_EN
      if (state_i == ST_IRQ) begin
         strb_o.pc_en   = 1'b1;
         strb_o.pc_in   = 1'b1;
         strb_o.pc_vec  = 1'b1;
         strb_o.irq_ack = 1'b1;
      end
`endif
   end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/INC/EXEC control FSM with HALT, optional interrupt entry and retired counter
// Ports: clock, rst (async high); opcode, zero, irq in; PC/memory/IR/ACC strobes, alu_op,
//        halted, irq_ack, retired count out
// Config: CPU_IRQ_EN enables irq sampling at end of EXEC, halt wake-up and the IRQ state
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter logic [7:0] IRQ_VECTOR = 8'hF0,
   parameter int         CYC_W      = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [2:0]       opcode,
   input  logic             zero,
   input  logic             irq,
   output logic             pc_en,
   output logic             pc_in,
   output logic             pc_vec,
   output logic             addr_sel,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ir_load,
   output logic             acc_load,
   output logic [2:0]       alu_op,
   output logic             halted,
   output logic             irq_ack,
   output logic [CYC_W-1:0] retired
);
   state_t           state_q, state_d;
   logic [CYC_W-1:0] retired_q, retired_d;
   strobe_t          strb, strb_out;
   logic             go_irq, unused_cfg;
   // The vector value itself is muxed into the PC outside this block; pc_vec only selects it.
`ifdef CPU_IRQ_EN
   localparam state_t ST_VEC = ST_IRQ;
   assign go_irq     = irq;
   assign unused_cfg = ^IRQ_VECTOR;
`else
   localparam state_t ST_VEC = ST_FETCH;
   assign go_irq     = 1'b0;
   assign unused_cfg = ^{IRQ_VECTOR, irq};
`endif
   seq_decode u_dec (
      .state_i  (state_q),
      .opcode_i (opcode),
      .zero_i   (zero),
      .strb_o   (strb)
   );
   always_comb begin
      case (state_q)
         ST_FETCH: state_d = ST_INC;
         ST_INC:   state_d = ST_EXEC;
         ST_EXEC:  state_d = (opcode == OP_HLT) ? ST_HALT : go_irq ? ST_VEC : ST_FETCH;
         ST_HALT:  state_d = go_irq ? ST_VEC : ST_HALT;
         default:  state_d = ST_FETCH;
      endcase
      retired_d = retired_q + CYC_W'((state_q == ST_EXEC) && (opcode != OP_HLT));
   end
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end
   // Strobes are silenced for the whole reset pulse so an abandoned instruction never writes.
   assign strb_out = rst ? '0 : strb;
   assign pc_en    = strb_out.pc_en;
   assign pc_in    = strb_out.pc_in;
   assign pc_vec   = strb_out.pc_vec;
   assign addr_sel = strb_out.addr_sel;
   assign mem_rd   = strb_out.mem_rd;
   assign mem_wr   = strb_out.mem_wr;
   assign ir_load  = strb_out.ir_load;
   assign acc_load = strb_out.acc_load;
   assign alu_op   = strb_out.alu_op;
   assign halted   = strb_out.halted;
   assign irq_ack  = strb_out.irq_ack;
   assign retired  = retired_q;
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter IRQ_VECTOR, default 8'hF0: PC target on interrupt entry (used only with CPU_IRQ_EN).
REQ-002 Parameter CYC_W, default 16: width of the retired-instruction counter.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  3  IR[7:5] from the instruction register; valid from the cycle after ir_load.
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 irq  input  1  level interrupt request (ignored without CPU_IRQ_EN).
REQ-008 pc_en  output  1  PC update enable.
REQ-009 pc_in  output  1  PC load select: 1 = load data, 0 = increment.
REQ-010 pc_vec  output  1  PC data mux selects IRQ_VECTOR instead of the IR operand.
REQ-011 addr_sel  output  1  memory address mux: 0 = PC, 1 = IR operand.
REQ-012 mem_rd, mem_wr, ir_load, acc_load  output  1 each  datapath strobes.
REQ-013 alu_op  output  3  opcode forwarded to the ALU during EXEC, else 3'b000.
REQ-014 halted  output  1  high while in HALT.
REQ-015 irq_ack  output  1  one-cycle pulse on interrupt entry.
REQ-016 retired  output  CYC_W  count of completed instructions.

Function
REQ-017 Opcodes: HLT 000, SKZ 001, ADD 010, AND 011, XOR 100, LDA 101, STO 110, JMP 111.
REQ-018 States: FETCH, INC, EXEC, HALT, IRQ; every non-halting instruction takes exactly 3 cycles (FETCH, INC, EXEC).
REQ-019 FETCH: addr_sel=0, mem_rd=1, ir_load=1; next state INC.
REQ-020 INC: pc_en=1, pc_in=0; next state EXEC.
REQ-021 EXEC ADD/AND/XOR/LDA: addr_sel=1, mem_rd=1, acc_load=1, alu_op=opcode.
REQ-022 EXEC STO: addr_sel=1, mem_wr=1; acc_load=0.
REQ-023 EXEC JMP: pc_en=1, pc_in=1, pc_vec=0.
REQ-024 EXEC SKZ: pc_en=1, pc_in=0 only when zero=1; otherwise no strobes.
REQ-025 EXEC HLT: no strobes; next state HALT, retired unchanged.
REQ-026 All other EXEC opcodes: next state FETCH (or IRQ per REQ-031); retired increments by 1 at the end of EXEC, wrapping modulo 2^CYC_W.
REQ-027 HALT: all strobes 0, halted=1; remains in HALT until reset (or REQ-032).
REQ-028 Outputs are decoded from the current state and opcode only; no output depends combinationally on irq.
REQ-029 At most one of mem_rd/mem_wr is high in any cycle; pc_en is never high in FETCH.

Reset
REQ-030 rst=1 asynchronously forces state FETCH, retired=0, irq pending flag=0, all strobes=0, halted=0; the first FETCH occurs on the first rising edge after rst deasserts; reset mid-instruction abandons that instruction without any strobe.

Configuration
REQ-031 With CPU_IRQ_EN defined: irq is sampled at the end of EXEC; if high, next state is IRQ instead of FETCH; IRQ drives pc_en=1, pc_in=1, pc_vec=1, irq_ack=1 for one cycle, then FETCH.
REQ-032 With CPU_IRQ_EN defined: irq=1 in HALT moves to IRQ (halt wake-up).
REQ-033 Without CPU_IRQ_EN: IRQ state does not exist; irq unused; pc_vec and irq_ack tied 0.

Structure
REQ-034 Package cpu_pkg holds the opcode constants and the state enum typedef, shared with the ALU and the top level.
REQ-035 One combinational sub-module, seq_decode, maps (state, opcode, zero) to the strobe vector; the FSM and the retired counter stay in cpu_sequencer.

Verification
REQ-036 Reset release, opcode=101 (LDA) held: cycles 1-3 show FETCH(mem_rd, ir_load), INC(pc_en, pc_in=0), EXEC(addr_sel, mem_rd, acc_load, alu_op=101); retired=1.
REQ-037 JMP: EXEC shows pc_en=1, pc_in=1, pc_vec=0; SKZ with zero=0 -> no pc_en in EXEC; SKZ with zero=1 -> pc_en=1, pc_in=0.
REQ-038 HLT: halted=1 from cycle 4 and stays high for 20 cycles, with no strobes and retired frozen.
REQ-039 rst pulsed mid-EXEC of STO: mem_wr drops immediately, retired=0, FETCH follows release.
REQ-040 CPU_IRQ_EN, irq=1 during an ADD EXEC: next cycle pc_en=1, pc_in=1, pc_vec=1, irq_ack=1 (PC <- 8'hF0), then FETCH; from HALT, irq=1 -> IRQ then FETCH, halted=0.
REQ-041 CYC_W=4: after 16 non-HLT instructions, retired wraps to 0.
